wid_fifo_ctrl: RTL



---
 rtl/wid_fifo_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/wid_fifo_ctrl.sv
// wid_fifo_ctrl: in-order write-ID queue for the AXI W channel.
// Each accepted AW pushes its AWID; the head is presented as WID for the
// current burst and retires on the W beat carrying WLAST. AW is held off
// while the queue is full, W while no ID is outstanding.
// Optional build macro WID_FIFO_BYPASS_EN: when the queue is empty, an AW
// pushed in the same cycle is presented as WID immediately (zero-cycle
// AW-to-W latency).
module wid_fifo_ctrl #(
  parameter int unsigned ID_W  = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             per_clk,
  input  logic             pad_cpu_rst_b,
  input  logic [ID_W-1:0]  biu_pad_awid,
  input  logic             biu_pad_awvalid,
  output logic             biu_pad_awready,
  output logic             pad_awvalid,
  input  logic             pad_awready,
  input  logic             biu_pad_wvalid,
  input  logic             biu_pad_wlast,
  output logic             biu_pad_wready,
  output logic             pad_wvalid,
  input  logic             pad_wready,
  output logic [ID_W-1:0]  wid,
  output logic             wid_vld,
  output logic [PTR_W:0]   wid_cnt,
  output logic             wid_full,
  output logic             wid_empty
);

  localparam logic [PTR_W:0] PtrOne = (PTR_W + 1)'(1);

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]  wptr_q, wptr_d;
  logic [PTR_W:0]  rptr_q, rptr_d;
  logic            push, pop;
  logic [ID_W-1:0] head;

  // Occupancy flags from the wrap-bit pointer pair.
  always_comb begin
    wid_empty = (wptr_q == rptr_q);
    wid_full  = (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]) &&
                (wptr_q[PTR_W] != rptr_q[PTR_W]);
    wid_cnt   = wptr_q - rptr_q;
    head      = mem_q[rptr_q[PTR_W-1:0]];
  end

  // AW gating: ready depends only on fullness, never on the W channel.
  always_comb begin
    pad_awvalid     = biu_pad_awvalid & ~wid_full;
    biu_pad_awready = pad_awready & ~wid_full;
    push            = biu_pad_awvalid & biu_pad_awready;
  end

  // Head ID selection; empty queue drives zero unless bypassing a fresh AW.
  always_comb begin
    wid_vld = ~wid_empty;
    wid     = wid_empty ? '0 : head;
`ifdef WID_FIFO_BYPASS_EN
    if (wid_empty && push) begin
      wid_vld = 1'b1;
      wid     = biu_pad_awid;
    end
`endif
  end

  // W gating: no beat leaves without a valid ID; WLAST retires the head.
  always_comb begin
    pad_wvalid     = biu_pad_wvalid & wid_vld;
    biu_pad_wready = pad_wready & wid_vld;
    pop            = biu_pad_wvalid & biu_pad_wready & biu_pad_wlast;
  end

  // Pointer next-state; wrap bit rolls naturally at 2*DEPTH.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + PtrOne;
    if (pop)  rptr_d = rptr_q + PtrOne;
  end

  // Pointer and storage registers; reset discards all outstanding IDs.
  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push) begin
        mem_q[wptr_q[PTR_W-1:0]] <= biu_pad_awid;
      end
    end
  end

endmodule
